// File: rtl/shift_pkg.sv
// Shared encodings and helpers for the multi-cycle shift sequencer.
// Imported by shift_stage and shift_sequencer.
package shift_pkg;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRA  = 2'b01;
    localparam logic [1:0] OP_SRL  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Distance applied by the stage selected by a given step index.
    function automatic int stage_dist(input int step);
        return 1 << step;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// Single shared shift stage: shifts 'in' by 2^step when enabled, left or right per op.
// Purely combinational; right shifts fill vacated bits with fill_bit.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   in,
    input  logic [SHAMT_W-1:0] step,
    input  logic               enable,
    input  logic [1:0]         op,
    input  logic               fill_bit,
    output logic [WIDTH-1:0]   out
);

    logic [WIDTH-1:0] fill_mask;

    always_comb begin
        fill_mask = ~({WIDTH{1'b1}} >> stage_dist(int'(step))) & {WIDTH{fill_bit}};
        out       = in;
        if (enable) begin
            case (op)
                OP_SLL:         out = in << stage_dist(int'(step));
                OP_SRA, OP_SRL: out = (in >> stage_dist(int'(step))) | fill_mask;
                default:        out = in;
            endcase
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRA shifter: one power-of-two stage per clock, MSB of shamt first, fixed latency.
// Optional macro SHIFT_SRL_EN enables op 10 as a logical right shift; otherwise op 10 decodes as SRA.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_start,
    input  logic [1:0]         ctrl_op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_resultRDY,
    output logic               busy
);

    localparam logic [SHAMT_W-1:0] LAST_STEP = SHAMT_W'(SHAMT_W - 1);

    state_t             state, next_state;
    logic [WIDTH-1:0]   work, stage_out;
    logic [SHAMT_W-1:0] amt, step;
    logic [1:0]         op_q, op_dec;
    logic               sign_q, fill_bit;

`ifdef SHIFT_SRL_EN
    assign op_dec   = ctrl_op;
    assign fill_bit = (op_q == OP_SRL) ? 1'b0 : sign_q;
`else
    assign op_dec   = (ctrl_op == OP_SRL) ? OP_SRA : ctrl_op;
    assign fill_bit = sign_q;
`endif

    shift_stage #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_stage (
        .in       (work),
        .step     (step),
        .enable   (amt[step]),
        .op       (op_q),
        .fill_bit (fill_bit),
        .out      (stage_out)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            work        <= '0;
            amt         <= '0;
            step        <= '0;
            op_q        <= OP_SLL;
            sign_q      <= 1'b0;
            data_result <= '0;
        end else begin
            state <= next_state;
            case (state)
                S_IDLE: begin
                    if (ctrl_start) begin
                        work   <= data_in;
                        amt    <= shamt;
                        op_q   <= op_dec;
                        sign_q <= data_in[WIDTH-1];
                        step   <= LAST_STEP;
                    end
                end
                S_SHIFT: begin
                    work <= stage_out;
                    step <= step - 1'b1;
                    // Publish on the last stage so the result is already valid during the RDY cycle.
                    if (step == '0) begin
                        data_result <= stage_out;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state     = state;
        data_resultRDY = 1'b0;
        busy           = 1'b0;
        case (state)
            S_IDLE: begin
                if (ctrl_start) begin
                    next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (step == '0) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                busy           = 1'b1;
                data_resultRDY = 1'b1;
                next_state     = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: cycle-level reference model plus literal expectations.
// Build with or without SHIFT_SRL_EN; the op 10 expectation follows the macro.
module tb_shift_sequencer;

    localparam int LAT = 6;

    logic        clock;
    logic        reset;
    logic        ctrl_start;
    logic [1:0]  ctrl_op;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        busy;

    int asserts  = 0;
    int failures = 0;

    // Reference model state: cycles of busy remaining, pending and visible result.
    int          m_cnt     = 0;
    logic [31:0] m_pending = '0;
    logic [31:0] m_result  = '0;
    bit          chk_en    = 0;

    shift_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_start     (ctrl_start),
        .ctrl_op        (ctrl_op),
        .data_in        (data_in),
        .shamt          (shamt),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] model_shift(input logic [1:0] op, input logic [31:0] d,
                                                input logic [4:0] s);
        logic [31:0] r;
        case (op)
            2'b00: r = d << s;
            2'b01: r = $signed(d) >>> s;
`ifdef SHIFT_SRL_EN
            2'b10: r = d >> s;
`else
            2'b10: r = $signed(d) >>> s;
`endif
            default: r = d;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) begin
        if (reset) begin
            m_cnt    = 0;
            m_result = '0;
        end else if (m_cnt == 0) begin
            if (ctrl_start) begin
                m_cnt     = LAT;
                m_pending = model_shift(ctrl_op, data_in, shamt);
            end
        end else begin
            m_cnt--;
            if (m_cnt == 1) m_result = m_pending;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("cyc busy", 32'(busy), 32'(m_cnt != 0));
            check("cyc rdy", 32'(data_resultRDY), 32'(m_cnt == 1));
            check("cyc result", data_result, m_result);
        end
    end

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] d,
                          input logic [4:0] s, input logic [31:0] exp);
        int lat  = 0;
        int bcnt = 0;
        @(posedge clock); #1;
        ctrl_start = 1'b1; ctrl_op = op; data_in = d; shamt = s;
        @(posedge clock); #1;
        ctrl_start = 1'b0; data_in = ~d; shamt = ~s;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (busy) bcnt++;
            if (data_resultRDY) begin
                lat = c;
                break;
            end
        end
        check({name, " model"}, m_pending, exp);
        check({name, " latency"}, 32'(lat), 32'(LAT));
        check({name, " busy cycles"}, 32'(bcnt), 32'(LAT));
        check({name, " result"}, data_result, exp);
    endtask

    initial begin
        int lat;
        int rdy_seen;
        reset = 1'b1; ctrl_start = 1'b0; ctrl_op = 2'b00; data_in = '0; shamt = '0;
        @(posedge clock); #1;
        chk_en = 1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("reset busy", 32'(busy), 32'd0);
        check("reset rdy", 32'(data_resultRDY), 32'd0);
        check("reset result", data_result, 32'h0);

        run_op("sra 16", 2'b01, 32'h8000_0000, 5'd16, 32'hFFFF_8000);
        run_op("sll 31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000);
        run_op("sll 0", 2'b00, 32'h1234_5678, 5'd0, 32'h1234_5678);
        run_op("sra pos 5", 2'b01, 32'h7FFF_FFFF, 5'd5, 32'h03FF_FFFF);
        run_op("sra 31", 2'b01, 32'hF000_0000, 5'd31, 32'hFFFF_FFFF);
        run_op("sll 31 odd", 2'b00, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000);

        // Start while busy and changed operands must be ignored.
        @(posedge clock); #1;
        ctrl_start = 1'b1; ctrl_op = 2'b01; data_in = 32'h8000_0000; shamt = 5'd4;
        @(posedge clock); #1;
        ctrl_start = 1'b0;
        @(posedge clock); #1;
        ctrl_start = 1'b1; ctrl_op = 2'b00; data_in = 32'h0000_FFFF; shamt = 5'd1;
        @(posedge clock); #1;
        ctrl_start = 1'b0; data_in = 32'h1234_0000;
        lat = 0;
        for (int c = 3; c <= 20; c++) begin
            @(negedge clock);
            if (data_resultRDY) begin
                lat = c;
                break;
            end
        end
        check("ignore latency", 32'(lat), 32'(LAT));
        check("ignore result", data_result, 32'hF800_0000);
        run_op("back to back", 2'b00, 32'h0000_00F0, 5'd8, 32'h0000_F000);

        // Reset in the third SHIFT cycle discards the operation.
        @(posedge clock); #1;
        ctrl_start = 1'b1; ctrl_op = 2'b00; data_in = 32'h0000_0001; shamt = 5'd3;
        @(posedge clock); #1;
        ctrl_start = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset result", data_result, 32'h0);
        rdy_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (data_resultRDY) rdy_seen++;
        end
        check("midreset no rdy", 32'(rdy_seen), 32'd0);

`ifdef SHIFT_SRL_EN
        run_op("op10", 2'b10, 32'h8000_0000, 5'd4, 32'h0800_0000);
`else
        run_op("op10", 2'b10, 32'h8000_0000, 5'd4, 32'hF800_0000);
`endif
        run_op("pass", 2'b11, 32'hA5A5_0F0F, 5'd7, 32'hA5A5_0F0F);
        run_op("sra neg 1", 2'b01, 32'h8000_0001, 5'd1, 32'hC000_0000);

        @(negedge clock);
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
